// File: rtl/weight_fetch.sv
// Streams one R x S filter's packed weight words from a 1-cycle-latency BRAM into weight_buffer.
// Build option WEIGHT_FETCH_ZERO_PAD_EN clears the unused low bits of every emitted word.
module weight_fetch #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int MAX_DIM    = 5
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic                  START,
   input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
   input  logic [3:0]            PARAM_R,
   input  logic [3:0]            PARAM_S,
   output logic                  BRAM_EN,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
   input  logic [DATA_WIDTH-1:0] BRAM_DOUT,
   input  logic                  BUF_WR_EN,
   input  logic                  BUF_FULL,
   output logic                  BUF_WR_VALID,
   output logic [DATA_WIDTH-1:0] BUF_WR_DATA,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   localparam logic [3:0] LP_MAX_DIM = 4'(MAX_DIM);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [3:0]            r_r;
   logic [3:0]            r_s;
   logic [3:0]            r_n;
   logic [3:0]            r_issued;
   logic [3:0]            r_sent;
   logic                  r_inflight;
   logic [DATA_WIDTH-1:0] r_mem [2];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;

   logic                  w_legal;
   logic [6:0]            w_r_x5;
   logic [3:0]            w_n;
   logic                  w_pop;
   logic                  w_last;
   logic                  w_issue;
   logic [DATA_WIDTH-1:0] w_head;

   assign w_legal = (PARAM_R != 4'd0) && (PARAM_R <= LP_MAX_DIM) &&
                    (PARAM_S != 4'd0) && (PARAM_S <= LP_MAX_DIM);
   // ceil(R*40/32) == floor((R*5 + 3) / 4)
   assign w_r_x5  = {3'd0, PARAM_R} * 7'd5 + 7'd3;
   assign w_n     = (PARAM_S == 4'd5) ? w_r_x5[5:2] : PARAM_R;

   assign BUF_WR_VALID = (r_state == S_FETCH) && (r_count != 2'd0) && !BUF_FULL;
   assign w_pop        = BUF_WR_VALID && BUF_WR_EN;
   assign w_last       = w_pop && (r_sent == r_n - 4'd1);

   // Crediting this cycle's pop keeps 1 word/cycle while never overfilling the 2-entry FIFO.
   assign w_issue   = (r_state == S_FETCH) && (r_issued < r_n) &&
                      (({1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);
   assign BRAM_EN   = w_issue;
   assign BRAM_ADDR = w_issue ? (r_base + {{(ADDR_WIDTH-4){1'b0}}, r_issued}) : '0;

   assign w_head = r_mem[r_rd_ptr];
   assign BUSY   = r_busy;
   assign DONE   = r_done;
   assign ERR    = r_err;

`ifdef WEIGHT_FETCH_ZERO_PAD_EN
   logic [9:0] w_bits;
   logic [7:0] w_rem;
   logic [7:0] w_keep;

   assign w_bits = {6'd0, r_r} * 10'd40;
   assign w_rem  = 8'(w_bits % 10'(DATA_WIDTH));

   always_comb begin
      w_keep = 8'(DATA_WIDTH);
      if (r_s < 4'd5)
         w_keep = {1'b0, r_s, 3'b000};
      else if ((r_sent == r_n - 4'd1) && (w_rem != 8'd0))
         w_keep = w_rem;
      BUF_WR_DATA = w_head & ({DATA_WIDTH{1'b1}} << (8'(DATA_WIDTH) - w_keep));
   end
`else
   assign BUF_WR_DATA = w_head;
`endif

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_r        <= '0;
         r_s        <= '0;
         r_n        <= '0;
         r_issued   <= '0;
         r_sent     <= '0;
         r_inflight <= 1'b0;
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_inflight <= w_issue;

         if (r_inflight) begin
            r_mem[r_wr_ptr] <= BRAM_DOUT;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
            r_sent   <= r_sent + 4'd1;
         end
         r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
         if (w_issue)
            r_issued <= r_issued + 4'd1;

         case (r_state)
            S_IDLE: begin
               if (START) begin
                  if (!w_legal) begin
                     r_err <= 1'b1;
                  end else if (!BUF_FULL) begin
                     r_base   <= BASE_ADDR;
                     r_r      <= PARAM_R;
                     r_s      <= PARAM_S;
                     r_n      <= w_n;
                     r_issued <= '0;
                     r_sent   <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (w_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch: BRAM model, per-cycle compare against a queue of expected words.
// Honours WEIGHT_FETCH_ZERO_PAD_EN in the expected-word model and the padding tests.
module tb_weight_fetch;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b0;
   logic        START = 1'b0;
   logic [11:0] BASE_ADDR = '0;
   logic [3:0]  PARAM_R = '0;
   logic [3:0]  PARAM_S = '0;
   logic        BRAM_EN;
   logic [11:0] BRAM_ADDR;
   logic [31:0] BRAM_DOUT = '0;
   logic        BUF_WR_EN = 1'b0;
   logic        BUF_FULL = 1'b0;
   logic        BUF_WR_VALID;
   logic [31:0] BUF_WR_DATA;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   weight_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MAX_DIM(5)) dut (
      .CLK(CLK), .RESETN(RESETN), .START(START), .BASE_ADDR(BASE_ADDR),
      .PARAM_R(PARAM_R), .PARAM_S(PARAM_S), .BRAM_EN(BRAM_EN), .BRAM_ADDR(BRAM_ADDR),
      .BRAM_DOUT(BRAM_DOUT), .BUF_WR_EN(BUF_WR_EN), .BUF_FULL(BUF_FULL),
      .BUF_WR_VALID(BUF_WR_VALID), .BUF_WR_DATA(BUF_WR_DATA), .BUSY(BUSY),
      .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   logic [31:0] mem [4096];
   always @(posedge CLK) if (BRAM_EN) BRAM_DOUT <= mem[BRAM_ADDR];

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err = 0;

   logic [31:0] exp_q [$];
   logic [11:0] addr_log [$];
   logic [31:0] xfer_log [$];
   int          xfer_cyc [$];
   int          n_xfer = 0;
   int          first_valid_cyc = -1;
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          err_cnt = 0;
   bit          busy_seen = 0;
   bit          m_active = 0;
   bit          en_rand = 0;
   int          start_cyc = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] exp_word(input logic [11:0] b, input int k, input int r,
                                            input int s, input int n);
      logic [11:0] a;
      logic [31:0] w;
      int          keep;
      a = b + 12'(k);
      w = mem[a];
      keep = 32;
`ifdef WEIGHT_FETCH_ZERO_PAD_EN
      if (s < 5) keep = 8 * s;
      else if ((k == n - 1) && ((r * 40) % 32 != 0)) keep = (r * 40) % 32;
      w = w & (32'hFFFF_FFFF << (32 - keep));
`else
      if (keep != 32 || r < 0 || s < 0 || n < 0) w = 'x;
`endif
      return w;
   endfunction

   // Compare process: every transfer is matched against the expected-word queue.
   bit          pv = 0, px = 0, pbusy = 0;
   logic [31:0] pdata = '0;
   always @(negedge CLK) begin
      bit xfer;
      if (!RESETN) begin
         pv = 0; px = 0; pbusy = 0;
      end else begin
         if (BRAM_EN) addr_log.push_back(BRAM_ADDR);
         if (BUSY) busy_seen = 1;
         if (ERR) err_cnt++;
         if (BUF_WR_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (BUF_FULL) check("valid_low_while_full", 32'(BUF_WR_VALID), 32'd0);
         if (pv && !px && BUF_WR_VALID) check("data_stable", BUF_WR_DATA, pdata);
         xfer = BUF_WR_VALID && BUF_WR_EN;
         if (xfer) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL unexpected_xfer: got 0x%08h, expected no transfer", BUF_WR_DATA);
            end else begin
               check("xfer_data", BUF_WR_DATA, exp_q.pop_front());
               if (exp_q.size() == 0) m_active = 0;
            end
            xfer_log.push_back(BUF_WR_DATA);
            xfer_cyc.push_back(cyc);
            n_xfer++;
         end
         if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_low_with_done", 32'(BUSY), 32'd0);
            check("busy_before_done", 32'(pbusy), 32'd1);
         end
         pv = BUF_WR_VALID; px = xfer; pdata = BUF_WR_DATA; pbusy = BUSY;
      end
   end

   initial begin
      forever begin
         @(posedge CLK); #1;
         if (en_rand) BUF_WR_EN = 1'($urandom_range(0, 1));
      end
   end

   task automatic clear_log();
      addr_log.delete(); xfer_log.delete(); xfer_cyc.delete();
      n_xfer = 0; first_valid_cyc = -1; done_cnt = 0; done_cyc = -1;
      err_cnt = 0; busy_seen = 0;
   endtask

   task automatic start_req(input logic [11:0] b, input int r, input int s);
      int n;
      @(posedge CLK); #1;
      BASE_ADDR = b; PARAM_R = 4'(r); PARAM_S = 4'(s); START = 1'b1;
      if (r >= 1 && r <= 5 && s >= 1 && s <= 5 && !BUF_FULL && !m_active) begin
         n = (s == 5) ? (r * 40 + 31) / 32 : r;
         for (int k = 0; k < n; k++) exp_q.push_back(exp_word(b, k, r, s, n));
         m_active = 1;
      end
      @(posedge CLK); #1;
      START = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_xfers(input int n, input int budget);
      for (int i = 0; i < budget && n_xfer < n; i++) begin @(posedge CLK); #2; end
      check("wait_xfers_timeout", 32'(n_xfer >= n), 32'd1);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) begin @(posedge CLK); #2; end
      check("wait_done_timeout", 32'(done_cnt > 0), 32'd1);
      repeat (3) @(posedge CLK);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 32'h5A00_0000 ^ (32'(a) * 32'h0001_0203);
      mem[12'h020] = 32'hAABB_CCDD;
      mem[12'h021] = 32'h1122_3344;
      mem[12'h022] = 32'h5566_7788;

      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      check("rst_bram_en", 32'(BRAM_EN), 32'd0);
      check("rst_bram_addr", 32'(BRAM_ADDR), 32'd0);
      check("rst_valid", 32'(BUF_WR_VALID), 32'd0);
      check("rst_data", BUF_WR_DATA, 32'd0);
      RESETN = 1'b1;

      // 5x5 at 0x010, sink always ready
      clear_log();
      BUF_WR_EN = 1'b1;
      start_req(12'h010, 5, 5);
      wait_done(100);
      check("t1_nreads", 32'(addr_log.size()), 32'd7);
      if (addr_log.size() == 7)
         for (int k = 0; k < 7; k++) check("t1_addr", 32'(addr_log[k]), 32'h010 + 32'(k));
      check("t1_nxfer", 32'(n_xfer), 32'd7);
      check("t1_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
      if (xfer_cyc.size() == 7) begin
         check("t1_back_to_back", 32'(xfer_cyc[6] - xfer_cyc[0]), 32'd6);
         check("t1_done_timing", 32'(done_cyc - xfer_cyc[6]), 32'd1);
      end
      check("t1_done_once", 32'(done_cnt), 32'd1);
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

      // 3x3 at 0x020 with a random sink enable
      clear_log();
      en_rand = 1;
      start_req(12'h020, 3, 3);
      wait_done(300);
      en_rand = 0;
      BUF_WR_EN = 1'b1;
      check("t2_nxfer", 32'(n_xfer), 32'd3);
      if (xfer_log.size() == 3) begin
`ifdef WEIGHT_FETCH_ZERO_PAD_EN
         check("t2_w0", xfer_log[0], 32'hAABB_CC00);
         check("t2_w1", xfer_log[1], 32'h1122_3300);
         check("t2_w2", xfer_log[2], 32'h5566_7700);
`else
         check("t2_w0", xfer_log[0], 32'hAABB_CCDD);
         check("t2_w1", xfer_log[1], 32'h1122_3344);
         check("t2_w2", xfer_log[2], 32'h5566_7788);
`endif
      end

      // 4x4 with BUF_FULL held for 5 cycles after the 2nd transfer
      clear_log();
      start_req(12'h040, 4, 4);
      wait_xfers(2, 50);
      BUF_FULL = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      BUF_FULL = 1'b0;
      wait_done(100);
      check("t3_nxfer", 32'(n_xfer), 32'd4);
      check("t3_nreads", 32'(addr_log.size()), 32'd4);
      if (xfer_cyc.size() == 4) begin
         check("t3_full_gap", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd6);
         check("t3_resume", 32'(xfer_cyc[3] - xfer_cyc[2]), 32'd1);
      end

      // illegal parameters and ignored STARTs
      clear_log();
      start_req(12'h080, 0, 3);
      repeat (4) @(posedge CLK);
      #1;
      check("t4_err_r0", 32'(err_cnt), 32'd1);
      check("t4_busy_r0", 32'(busy_seen), 32'd0);
      check("t4_reads_r0", 32'(addr_log.size()), 32'd0);
      clear_log();
      start_req(12'h080, 2, 6);
      repeat (4) @(posedge CLK);
      #1;
      check("t4_err_s6", 32'(err_cnt), 32'd1);
      check("t4_busy_s6", 32'(busy_seen), 32'd0);
      check("t4_reads_s6", 32'(addr_log.size()), 32'd0);
      clear_log();
      BUF_FULL = 1'b1;
      start_req(12'h080, 2, 2);
      repeat (4) @(posedge CLK);
      #1;
      BUF_FULL = 1'b0;
      check("t4_full_busy", 32'(busy_seen), 32'd0);
      check("t4_full_err", 32'(err_cnt), 32'd0);
      clear_log();
      BUF_WR_EN = 1'b0;
      start_req(12'h0A0, 2, 2);
      start_req(12'h0C0, 5, 5);
      BUF_WR_EN = 1'b1;
      wait_done(100);
      check("t4_busy_nxfer", 32'(n_xfer), 32'd2);
      check("t4_busy_nreads", 32'(addr_log.size()), 32'd2);
      if (addr_log.size() == 2) begin
         check("t4_busy_a0", 32'(addr_log[0]), 32'h0A0);
         check("t4_busy_a1", 32'(addr_log[1]), 32'h0A1);
      end

      // address wrap: R=1, S=5 at 0xFFF
      clear_log();
      start_req(12'hFFF, 1, 5);
      wait_done(100);
      check("wrap_nxfer", 32'(n_xfer), 32'd2);
      if (addr_log.size() == 2) begin
         check("wrap_a0", 32'(addr_log[0]), 32'hFFF);
         check("wrap_a1", 32'(addr_log[1]), 32'h000);
      end else check("wrap_nreads", 32'(addr_log.size()), 32'd2);

      // reset during a 5x5 after 3 transfers
      clear_log();
      start_req(12'h010, 5, 5);
      wait_xfers(3, 50);
      RESETN = 1'b0;
      #1;
      check("t5_busy", 32'(BUSY), 32'd0);
      check("t5_valid", 32'(BUF_WR_VALID), 32'd0);
      check("t5_bram_en", 32'(BRAM_EN), 32'd0);
      check("t5_done", 32'(DONE), 32'd0);
      check("t5_data", BUF_WR_DATA, 32'd0);
      exp_q.delete();
      m_active = 0;
      @(posedge CLK);
      #1;
      RESETN = 1'b1;
      clear_log();
      start_req(12'h100, 2, 2);
      wait_done(100);
      check("t5_nxfer", 32'(n_xfer), 32'd2);
      check("t5_nreads", 32'(addr_log.size()), 32'd2);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef WEIGHT_FETCH_ZERO_PAD_EN
      for (int a = 12'h200; a < 12'h208; a++) mem[a] = 32'hFFFF_FFFF;
      clear_log();
      start_req(12'h200, 5, 5);
      wait_done(100);
      if (xfer_log.size() == 7) begin
         check("pad55_w0", xfer_log[0], 32'hFFFF_FFFF);
         check("pad55_w6", xfer_log[6], 32'hFF00_0000);
      end else check("pad55_nxfer", 32'(xfer_log.size()), 32'd7);
      clear_log();
      start_req(12'h200, 3, 3);
      wait_done(100);
      if (xfer_log.size() == 3)
         for (int k = 0; k < 3; k++) check("pad33_w", xfer_log[k], 32'hFFFF_FF00);
      else check("pad33_nxfer", 32'(xfer_log.size()), 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
